// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: computes A - B - Bin one bit per clock through a single registered full-subtractor cell, LSB first
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_bw, r_bout, r_v;
    logic             w_a, w_b, w_d, w_bw, w_last;
    always_comb begin
        w_a    = r_a[0];
        w_b    = r_b[0];
        w_d    = w_a ^ w_b ^ r_bw;
        w_bw   = (~w_a & w_b) | (~(w_a ^ w_b) & r_bw);
        w_last = r_cnt == CW'(WIDTH - 1);
        w_next = r_state == RUN ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
    end
    // On the last bit the A/B LSBs are the operand sign bits, so V needs no extra storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_bw    <= 1'b0;
            r_bout  <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != RUN && start) begin
                r_a   <= A;
                r_b   <= B;
                r_bw  <= Bin;
                r_cnt <= '0;
                r_res <= '0;
            end else if (r_state == RUN) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= {w_d, r_res[WIDTH-1:1]};
                r_bw  <= w_bw;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_d    <= {w_d, r_res[WIDTH-1:1]};
                    r_bout <= w_bw;
                    r_v    <= (w_a ^ w_b) & (w_d ^ w_a);
                end
            end
        end
    end
    assign busy = r_state == RUN;
    assign done = r_state == DONE;
    assign D    = r_d;
    assign Bout = r_bout;
    assign V    = r_v;
endmodule
